// File: rtl/bcd_converter_seq_if.sv
// Valid/ready handshake bundle for the sequential binary-to-BCD converter.
// The master drives the request side and accepts results; the slave is the converter.
interface bcd_converter_seq_if #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BIN_WIDTH-1:0]   in_binary;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*DIGITS-1:0]    out_bcd;
    logic                   out_overflow;
    logic [DIGITS-1:0]      out_blank;

    modport master (
        output in_valid, in_binary, out_ready,
        input  in_ready, out_valid, out_bcd, out_overflow, out_blank
    );

    modport slave (
        input  in_valid, in_binary, out_ready,
        output in_ready, out_valid, out_bcd, out_overflow, out_blank
    );
endinterface

// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BCD_LEADING_ZERO_BLANK_EN to produce the leading-zero mask on out_blank.
module bcd_converter_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_converter_seq_if.slave   s_bus
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int AW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_cnt;
    logic [BIN_WIDTH-1:0]    r_bin;
    logic [AW-1:0]           r_acc;
    logic                    r_ovf;
    logic [AW-1:0]           r_bcd;
    logic                    r_out_ovf;
    logic [DIGITS-1:0]       r_blank;

    logic [AW-1:0]           w_adj;
    logic [AW+BIN_WIDTH-1:0] w_shift;
    logic [AW-1:0]           w_acc_nx;
    logic                    w_ovf_nx;
    logic                    w_last;
    logic [DIGITS-1:0]       w_blank;

    // Digits are adjusted independently; no carry crosses a digit boundary.
    always_comb begin
        w_adj = r_acc;
        for (int k = 0; k < DIGITS; k++)
            if (r_acc[4*k +: 4] >= 4'd5)
                w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
    end

    assign w_shift  = {w_adj, r_bin} << 1;
    assign w_acc_nx = w_shift[BIN_WIDTH +: AW];
    assign w_ovf_nx = r_ovf | w_adj[AW-1];
    assign w_last   = (r_cnt == CW'(BIN_WIDTH - 1));

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic w_zrun;
    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        w_blank = '0;
        w_zrun  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zrun     = w_zrun & (w_acc_nx[4*k +: 4] == 4'd0);
            w_blank[k] = w_zrun;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (s_bus.in_valid)  w_next = SHIFT;
            SHIFT:   if (w_last)          w_next = DONE;
            DONE:    if (s_bus.out_ready) w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bin     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
            r_out_ovf <= 1'b0;
            r_blank   <= '0;
        end else begin
            case (r_state)
                IDLE: if (s_bus.in_valid) begin
                    r_bin <= s_bus.in_binary;
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                    r_cnt <= '0;
                end
                SHIFT: begin
                    r_acc <= w_acc_nx;
                    r_bin <= w_shift[BIN_WIDTH-1:0];
                    r_ovf <= w_ovf_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd     <= w_acc_nx;
                        r_out_ovf <= w_ovf_nx;
                        r_blank   <= w_blank;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_bus.in_ready     = (r_state == IDLE);
    assign s_bus.out_valid    = (r_state == DONE);
    assign s_bus.out_bcd      = r_bcd;
    assign s_bus.out_overflow = r_out_ovf;
    assign s_bus.out_blank    = r_blank;
endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: three parameterisations checked every cycle
// against an arithmetic model, plus directed vectors with literal results.
module tb_bcd_converter_seq;
    localparam int BWS [3] = '{8, 10, 16};
    localparam int DGS [3] = '{3, 3, 5};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        t_iv [3];
    logic [15:0] t_in [3];
    logic        t_or [3];
    logic        a_ir [3];
    logic        a_ov [3];
    logic [19:0] a_bcd [3];
    logic        a_ovf [3];
    logic [4:0]  a_blank [3];

    bcd_converter_seq_if #(.BIN_WIDTH(8),  .DIGITS(3)) if0 ();
    bcd_converter_seq_if #(.BIN_WIDTH(10), .DIGITS(3)) if1 ();
    bcd_converter_seq_if #(.BIN_WIDTH(16), .DIGITS(5)) if2 ();

    bcd_converter_seq #(.BIN_WIDTH(8),  .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .s_bus(if0));
    bcd_converter_seq #(.BIN_WIDTH(10), .DIGITS(3)) u1 (.clk(clk), .rst_n(rst_n), .s_bus(if1));
    bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .rst_n(rst_n), .s_bus(if2));

    assign if0.in_valid = t_iv[0]; assign if0.in_binary = t_in[0][7:0]; assign if0.out_ready = t_or[0];
    assign if1.in_valid = t_iv[1]; assign if1.in_binary = t_in[1][9:0]; assign if1.out_ready = t_or[1];
    assign if2.in_valid = t_iv[2]; assign if2.in_binary = t_in[2];      assign if2.out_ready = t_or[2];

    assign a_ir[0] = if0.in_ready;  assign a_ov[0] = if0.out_valid;
    assign a_ir[1] = if1.in_ready;  assign a_ov[1] = if1.out_valid;
    assign a_ir[2] = if2.in_ready;  assign a_ov[2] = if2.out_valid;
    assign a_bcd[0] = {8'd0, if0.out_bcd};  assign a_ovf[0] = if0.out_overflow;  assign a_blank[0] = {2'd0, if0.out_blank};
    assign a_bcd[1] = {8'd0, if1.out_bcd};  assign a_ovf[1] = if1.out_overflow;  assign a_blank[1] = {2'd0, if1.out_blank};
    assign a_bcd[2] = if2.out_bcd;          assign a_ovf[2] = if2.out_overflow;  assign a_blank[2] = if2.out_blank;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint f_pow(input int d);
        longint p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] f_bcd(input longint v, input int d);
        logic [19:0] r = '0;
        longint p = 1;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic f_ovf(input longint v, input int d);
        return v >= f_pow(d);
    endfunction

    function automatic logic [4:0] f_blank(input longint v, input int d);
        logic [4:0] r = '0;
        longint t = v % f_pow(d);
        longint p = 10;
        for (int k = 1; k < d; k++) begin
            r[k] = ((t / p) == 0);
            p = p * 10;
        end
`ifndef BCD_LEADING_ZERO_BLANK_EN
        r = '0;
`endif
        return r;
    endfunction

    function automatic logic [4:0] lb(input logic [4:0] x);
        logic [4:0] r = x;
`ifndef BCD_LEADING_ZERO_BLANK_EN
        r = '0;
`endif
        return r;
    endfunction

    // phase: 0 waiting for input, 1 converting, 2 result offered
    int          m_ph [3];
    int          m_cnt [3];
    logic [15:0] m_val [3];
    logic [19:0] m_bcd [3];
    logic        m_ovf [3];
    logic [4:0]  m_blank [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_ph[i] <= 0; m_cnt[i] <= 0; m_val[i] <= '0;
                m_bcd[i] <= '0; m_ovf[i] <= 1'b0; m_blank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (m_ph[i])
                    0: if (t_iv[i]) begin
                        m_ph[i] <= 1; m_cnt[i] <= 0; m_val[i] <= t_in[i];
                    end
                    1: begin
                        m_cnt[i] <= m_cnt[i] + 1;
                        if (m_cnt[i] + 1 == BWS[i]) begin
                            m_ph[i]    <= 2;
                            m_bcd[i]   <= f_bcd(longint'(m_val[i]), DGS[i]);
                            m_ovf[i]   <= f_ovf(longint'(m_val[i]), DGS[i]);
                            m_blank[i] <= f_blank(longint'(m_val[i]), DGS[i]);
                        end
                    end
                    default: if (t_or[i]) m_ph[i] <= 0;
                endcase
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc u%0d in_ready", i),  64'(a_ir[i]),    64'(m_ph[i] == 0));
                chk($sformatf("cyc u%0d out_valid", i), 64'(a_ov[i]),    64'(m_ph[i] == 2));
                chk($sformatf("cyc u%0d out_bcd", i),   64'(a_bcd[i]),   64'(m_bcd[i]));
                chk($sformatf("cyc u%0d overflow", i),  64'(a_ovf[i]),   64'(m_ovf[i]));
                chk($sformatf("cyc u%0d blank", i),     64'(a_blank[i]), 64'(m_blank[i]));
            end
        end
    end

    // ---------------- stimulus helpers (called at edge+1) ----------------
    task automatic accept(input int i, input int v);
        bit ok = 1'b0;
        t_iv[i] = 1'b1; t_in[i] = 16'(v);
        for (int c = 0; c < 60 && !ok; c++) begin
            if (a_ir[i]) ok = 1'b1;
            @(posedge clk); #1;
        end
        t_iv[i] = 1'b0;
        chk($sformatf("accept u%0d %0d", i, v), 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input int i, output int n);
        n = 0;
        while (!a_ov[i] && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    int lat, cnt;

    initial begin
        for (int i = 0; i < 3; i++) begin t_iv[i] = 1'b0; t_in[i] = '0; t_or[i] = 1'b1; end
        #1 rst_n = 1'b0;
        // model pinned to hand-derived values
        chk("model 255",   64'(f_bcd(255, 3)),   64'h255);
        chk("model 1023",  64'(f_bcd(1023, 3)),  64'h023);
        chk("model 65535", 64'(f_bcd(65535, 5)), 64'h65535);
        chk("model ovf",   64'(f_ovf(1000, 3)),  64'd1);
        chk("model ovf2",  64'(f_ovf(999, 3)),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",  64'(a_ir[0]),  64'd1);
        chk("rst out_valid", 64'(a_ov[0]),  64'd0);
        chk("rst out_bcd",   64'(a_bcd[0]), 64'd0);
        chk("rst overflow",  64'(a_ovf[0]), 64'd0);
        chk("rst blank",     64'(a_blank[0]), 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // zero, held in DONE
        t_or[0] = 1'b0;
        accept(0, 0);
        wait_valid(0, lat);
        chk("lat zero", 64'(lat), 64'd8);
        chk("bcd zero", 64'(a_bcd[0]), 64'h000);
        chk("ovf zero", 64'(a_ovf[0]), 64'd0);
        chk("blank zero", 64'(a_blank[0]), 64'(lb(5'b00110)));
        t_or[0] = 1'b1;
        @(posedge clk); #1;

        // back-to-back with out_ready high
        begin
            int          vals [4] = '{255, 200, 99, 7};
            logic [11:0] exps [4] = '{12'h255, 12'h200, 12'h099, 12'h007};
            logic [4:0]  blks [4] = '{5'b00000, 5'b00000, 5'b00100, 5'b00110};
            for (int j = 0; j < 4; j++) begin
                accept(0, vals[j]);
                cnt = 0;
                while (!a_ir[0] && cnt < 100) begin cnt++; @(posedge clk); #1; end
                chk($sformatf("busy cycles %0d", vals[j]), 64'(cnt), 64'd9);
                chk($sformatf("bcd %0d", vals[j]), 64'(a_bcd[0]), 64'(exps[j]));
                chk($sformatf("blank %0d", vals[j]), 64'(a_blank[0]), 64'(lb(blks[j])));
            end
        end

        // back-pressure with a pending request that must wait
        t_or[0] = 1'b0;
        accept(0, 123);
        t_iv[0] = 1'b1; t_in[0] = 16'd45;
        wait_valid(0, lat);
        chk("lat 123", 64'(lat), 64'd8);
        for (int c = 0; c < 5; c++) begin
            chk("bp out_valid", 64'(a_ov[0]),  64'd1);
            chk("bp bcd",       64'(a_bcd[0]), 64'h123);
            chk("bp in_ready",  64'(a_ir[0]),  64'd0);
            @(posedge clk); #1;
        end
        t_or[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp idle", 64'(a_ir[0]), 64'd1);
        @(posedge clk); #1;
        t_iv[0] = 1'b0;
        chk("bp took 45", 64'(a_ir[0]), 64'd0);
        wait_valid(0, lat);
        chk("lat 45", 64'(lat), 64'd8);
        chk("bcd 45", 64'(a_bcd[0]), 64'h045);
        @(posedge clk); #1;

        // 10-bit / 3-digit overflow edges
        begin
            int          vals [3] = '{1023, 999, 1000};
            logic [11:0] exps [3] = '{12'h023, 12'h999, 12'h000};
            logic        ovfs [3] = '{1'b1, 1'b0, 1'b1};
            for (int j = 0; j < 3; j++) begin
                accept(1, vals[j]);
                wait_valid(1, lat);
                chk($sformatf("w10 lat %0d", vals[j]), 64'(lat), 64'd10);
                chk($sformatf("w10 bcd %0d", vals[j]), 64'(a_bcd[1]), 64'(exps[j]));
                chk($sformatf("w10 ovf %0d", vals[j]), 64'(a_ovf[1]), 64'(ovfs[j]));
                @(posedge clk); #1;
            end
        end

        // 16-bit / 5-digit
        accept(2, 65535);
        wait_valid(2, lat);
        chk("w16 lat", 64'(lat), 64'd16);
        chk("w16 bcd", 64'(a_bcd[2]), 64'h65535);
        chk("w16 ovf", 64'(a_ovf[2]), 64'd0);
        @(posedge clk); #1;

        // reset in the middle of a conversion
        accept(0, 255);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready",  64'(a_ir[0]),    64'd1);
        chk("mid rst out_valid", 64'(a_ov[0]),    64'd0);
        chk("mid rst bcd",       64'(a_bcd[0]),   64'd0);
        chk("mid rst ovf",       64'(a_ovf[0]),   64'd0);
        chk("mid rst blank",     64'(a_blank[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (a_ov[0]) cnt++;
            @(posedge clk); #1;
        end
        chk("no result after rst", 64'(cnt), 64'd0);
        accept(0, 42);
        wait_valid(0, lat);
        chk("lat 42", 64'(lat), 64'd8);
        chk("bcd 42", 64'(a_bcd[0]), 64'h042);
        repeat (3) begin @(posedge clk); #1; end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
